// File: rtl/debounce_sync.sv
// Per-bit two-flop synchroniser followed by a 4-state qualify FSM per channel.
// A level change reaches y only after it has been stable for CNT_MAX cycles.
module debounce_sync #(
    parameter int WIDTH   = 1,
    parameter int CNT_MAX = 1_000_000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] busy
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    localparam logic [1:0] STABLE0 = 2'd0;
    localparam logic [1:0] TRY1    = 2'd1;
    localparam logic [1:0] STABLE1 = 2'd2;
    localparam logic [1:0] TRY0    = 2'd3;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s;

    // Plain flop chain: nothing may sit between the two stages.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= x;
            s  <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [1:0]       state;
        logic [CNT_W-1:0] cnt;
        logic             y_q;
        logic             busy_q;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state  <= STABLE0;
                cnt    <= '0;
                y_q    <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    STABLE0: begin
                        if (s[i]) begin
                            state  <= TRY1;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    TRY1: begin
                        if (!s[i]) begin
                            state  <= STABLE0;
                            busy_q <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE1;
                            y_q    <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STABLE1: begin
                        if (!s[i]) begin
                            state  <= TRY0;
                            cnt    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    TRY0: begin
                        if (s[i]) begin
                            state  <= STABLE1;
                            busy_q <= 1'b0;
                        end else if (cnt == CNT_LAST) begin
                            state  <= STABLE0;
                            y_q    <= 1'b0;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= STABLE0;
                        cnt    <= '0;
                        y_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end

        // The counter saturates at the completion value; it must never run past it.
        a_cnt_bound: assert property (@(posedge clk) disable iff (!rstn) cnt <= CNT_LAST);

        assign y[i]    = y_q;
        assign busy[i] = busy_q;
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed latency scenarios plus random bouncing inputs,
// all checked every cycle by a scoreboard fed from a window-based reference model.
module tb_debounce_sync;

    localparam int WIDTH   = 2;
    localparam int CNT_MAX = 4;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic [WIDTH-1:0] x    = '0;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] busy;
    logic             xFast = 1'b0;
    logic             yFast;
    logic             busyFast;

    int edgeNum   = 0;
    int numChecks = 0;
    int numErrors = 0;

    logic [WIDTH-1:0]   xHist[$];
    logic               rHist[$];
    bit                 win[WIDTH][$];
    logic [WIDTH-1:0]   yModel = '0;
    logic [2*WIDTH-1:0] expQ[$];

    debounce_sync #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .x    (x),
        .y    (y),
        .busy (busy)
    );

    debounce_sync #(.WIDTH(1), .CNT_MAX(1)) fastDut (
        .clk  (clk),
        .rstn (rstn),
        .x    (xFast),
        .y    (yFast),
        .busy (busyFast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeNum++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeNum);
        end
    endtask

    // Reference model: the FSM sees x two sampling edges late (zero if either of
    // those edges was in reset); y flips once its last CNT_MAX+1 views all disagree with it.
    always @(posedge clk) begin
        logic [WIDTH-1:0] seen;
        logic [WIDTH-1:0] busyModel;
        int n;
        bit allDiff;
        xHist.push_back(x);
        rHist.push_back(rstn);
        n = xHist.size() - 1;
        seen = '0;
        if (n >= 2 && rHist[n-1] && rHist[n-2]) seen = xHist[n-2];
        busyModel = '0;
        if (!rstn) begin
            yModel = '0;
            for (int ch = 0; ch < WIDTH; ch++) win[ch].delete();
        end else begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                win[ch].push_back(seen[ch]);
                if (win[ch].size() > CNT_MAX + 1) void'(win[ch].pop_front());
                if (win[ch].size() == CNT_MAX + 1) begin
                    allDiff = 1'b1;
                    for (int k = 0; k < win[ch].size(); k++)
                        if (win[ch][k] == yModel[ch]) allDiff = 1'b0;
                    if (allDiff) yModel[ch] = ~yModel[ch];
                end
                busyModel[ch] = (seen[ch] != yModel[ch]);
            end
        end
        expQ.push_back({yModel, busyModel});
    end

    // Monitor: one expected {y, busy} per clock edge, compared just after the edge.
    always @(posedge clk) begin
        logic [2*WIDTH-1:0] expVal;
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            expVal = expQ.pop_front();
            checkOutput("scoreboard_y_busy", 32'({y, busy}), 32'(expVal));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] xv, input logic rv, input int n);
        x    = xv;
        rstn = rv;
        repeat (n) @(negedge clk);
    endtask

    // Call right after driving at a negedge; latencies are counted in clock edges.
    task automatic measureEdges(input int idx, input logic level, output int busyLat, output int yLat);
        int start;
        start   = edgeNum;
        busyLat = -1;
        yLat    = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busyLat < 0 && busy[idx]) busyLat = edgeNum - start;
            if (y[idx] == level) begin
                yLat = edgeNum - start;
                break;
            end
        end
    endtask

    task automatic resetAndIdle();
        applyStimulus('0, 1'b0, 2);
        applyStimulus('0, 1'b1, 5);
    endtask

    initial begin
        int bLat;
        int yLat;
        int fastLat;
        bit sawLow;
        bit sawBusy;
        int holdLeft[WIDTH];
        logic [WIDTH-1:0] xr;

        // Reset holds everything cleared even with inputs high
        applyStimulus(2'b11, 1'b0, 3);
        checkOutput("reset_y", 32'(y), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        measureEdges(0, 1'b1, bLat, yLat);
        checkOutput("release_rise_latency", 32'(yLat), 32'd7);
        checkOutput("release_both_high", 32'(y), 32'd3);

        // Clean press on channel 0
        resetAndIdle();
        x = 2'b01;
        measureEdges(0, 1'b1, bLat, yLat);
        checkOutput("press_busy_latency", 32'(bLat), 32'd3);
        checkOutput("press_rise_latency", 32'(yLat), 32'd7);
        checkOutput("press_busy_done", 32'(busy[0]), 32'd0);
        checkOutput("press_other_low", 32'(y[1]), 32'd0);

        // Bounce: 1,1,0 then held high
        resetAndIdle();
        applyStimulus(2'b01, 1'b1, 2);
        applyStimulus(2'b00, 1'b1, 1);
        x = 2'b01;
        measureEdges(0, 1'b1, bLat, yLat);
        checkOutput("bounce_rise_latency", 32'(yLat), 32'd7);

        // Release, re-press, then a short low glitch that must be filtered
        x = 2'b00;
        measureEdges(0, 1'b0, bLat, yLat);
        checkOutput("release_fall_latency", 32'(yLat), 32'd7);
        x = 2'b01;
        measureEdges(0, 1'b1, bLat, yLat);
        checkOutput("repress_rise_latency", 32'(yLat), 32'd7);
        applyStimulus(2'b01, 1'b1, 10);
        sawLow  = 1'b0;
        sawBusy = 1'b0;
        x = 2'b00;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 2) x = 2'b01;
            if (!y[0]) sawLow = 1'b1;
            if (busy[0]) sawBusy = 1'b1;
        end
        checkOutput("glitch_y_held", 32'(sawLow), 32'd0);
        checkOutput("glitch_busy_seen", 32'(sawBusy), 32'd1);

        // Reset in the middle of qualification on channel 1
        resetAndIdle();
        applyStimulus(2'b10, 1'b1, 4);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("midreset_y", 32'(y), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        measureEdges(1, 1'b1, bLat, yLat);
        checkOutput("midreset_rise_latency", 32'(yLat), 32'd7);

        // Both channels together, then the CNT_MAX=1 instance
        resetAndIdle();
        x = 2'b11;
        measureEdges(0, 1'b1, bLat, yLat);
        checkOutput("both_rise_latency", 32'(yLat), 32'd7);
        checkOutput("both_same_edge", 32'(y), 32'd3);
        fastLat = -1;
        begin
            int start;
            start = edgeNum;
            xFast = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (yFast) begin
                    fastLat = edgeNum - start;
                    break;
                end
            end
        end
        checkOutput("fast_rise_latency", 32'(fastLat), 32'd4);

        // Random bouncing inputs with occasional resets
        for (int ch = 0; ch < WIDTH; ch++) holdLeft[ch] = 0;
        xr = x;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                if (holdLeft[ch] == 0) begin
                    xr[ch] = 1'($urandom_range(0, 1));
                    holdLeft[ch] = $urandom_range(1, 2 * CNT_MAX + 4);
                end
                holdLeft[ch]--;
            end
            if ($urandom_range(0, 299) == 0) applyStimulus(xr, 1'b0, $urandom_range(1, 3));
            else applyStimulus(xr, 1'b1, 1);
        end

        applyStimulus(xr, 1'b1, 3);
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
